// File: rtl/ja88_pkg.sv
// Shared types for the ModR/M operand sequencer: FSM state encoding, mod/rm
// constants and the 8-bit register byte-select/merge rule.
package ja88_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DISP_LO  = 4'd1,
        ST_DISP_HI  = 4'd2,
        ST_READ_LO  = 4'd3,
        ST_READ_HI  = 4'd4,
        ST_EXEC     = 4'd5,
        ST_WRITE_LO = 4'd6,
        ST_WRITE_HI = 4'd7,
        ST_DONE     = 4'd8
    } state_e;

    localparam logic [1:0] MOD_MEM    = 2'd0;
    localparam logic [1:0] MOD_DISP8  = 2'd1;
    localparam logic [1:0] MOD_DISP16 = 2'd2;
    localparam logic [1:0] MOD_REG    = 2'd3;

    localparam logic [2:0] RM_BX_SI = 3'd0;
    localparam logic [2:0] RM_BX_DI = 3'd1;
    localparam logic [2:0] RM_BP_SI = 3'd2;
    localparam logic [2:0] RM_BP_DI = 3'd3;
    localparam logic [2:0] RM_SI    = 3'd4;
    localparam logic [2:0] RM_DI    = 3'd5;
    localparam logic [2:0] RM_BP    = 3'd6;
    localparam logic [2:0] RM_BX    = 3'd7;

    // Byte registers: idx[1:0] names the word (AX..BX), idx[2] picks its high byte.
    function automatic logic [15:0] reg_rd_sel(input logic [15:0] word,
                                               input logic        hi_byte,
                                               input logic        isize);
        if (isize)
            return word;
        return {8'h00, (hi_byte ? word[15:8] : word[7:0])};
    endfunction

    function automatic logic [15:0] reg_wr_merge(input logic [15:0] old_word,
                                                 input logic [15:0] res,
                                                 input logic        hi_byte,
                                                 input logic        isize);
        if (isize)
            return res;
        return hi_byte ? {res[7:0], old_word[7:0]} : {old_word[15:8], res[7:0]};
    endfunction

endpackage

// File: rtl/ja88_ea.sv
// Combinational 16-bit effective-address offset and default-segment (SS vs DS)
// selection from a ModR/M byte, displacement and base/index registers.
module ja88_ea
    import ja88_pkg::*;
(
    input  logic [7:0]  modrm,
    input  logic [15:0] disp,
    input  logic [15:0] bx,
    input  logic [15:0] bp,
    input  logic [15:0] si,
    input  logic [15:0] di,
    output logic [15:0] offset,
    output logic        use_ss
);

    logic [1:0]  mod_f;
    logic [2:0]  rm_f;
    logic [15:0] base;
    logic        unused_reg_field;

    assign mod_f            = modrm[7:6];
    assign rm_f             = modrm[2:0];
    assign unused_reg_field = ^modrm[5:3];

    always_comb begin
        base   = 16'h0000;
        use_ss = 1'b0;
        case (rm_f)
            RM_BX_SI: base = bx + si;
            RM_BX_DI: base = bx + di;
            RM_BP_SI: begin base = bp + si; use_ss = 1'b1; end
            RM_BP_DI: begin base = bp + di; use_ss = 1'b1; end
            RM_SI:    base = si;
            RM_DI:    base = di;
            RM_BP: begin
                // mod=0 with rm=6 is the direct-address form: displacement only.
                if (mod_f != MOD_MEM) begin
                    base   = bp;
                    use_ss = 1'b1;
                end
            end
            default:  base = bx;
        endcase
        offset = base + disp;
    end

endmodule

// File: rtl/modrm_operand.sv
// ModR/M operand sequencer: fetches displacement, reads the r/m operand from
// memory or the register file, hands operands to the ALU and writes back.
// Optional feature macro SEG_OVERRIDE_EN adds a segment-override input pair.
//
// state     | meaning
// IDLE      | waiting for start
// DISP_LO   | consume displacement low byte (or sign-extended disp8)
// DISP_HI   | consume displacement high byte
// READ_LO   | read memory operand byte at EA
// READ_HI   | read memory operand byte at EA+1 (16-bit only)
// EXEC      | present op1/op2 until result_valid
// WRITE_LO  | write result byte to EA
// WRITE_HI  | write result byte to EA+1 (16-bit only)
// DONE      | one-cycle done pulse, register write-back
module modrm_operand
    import ja88_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        modrm,
    input  logic              isize,
    input  logic              dir,
    input  logic              wb,
    input  logic [15:0]       bx,
    input  logic [15:0]       bp,
    input  logic [15:0]       si,
    input  logic [15:0]       di,
    input  logic [15:0]       seg_ds,
    input  logic [15:0]       seg_ss,
    input  logic              ib_valid,
    input  logic [7:0]        ib_data,
    output logic              ib_ready,
    output logic [2:0]        reg_ridx,
    input  logic [15:0]       reg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       op1,
    output logic [15:0]       op2,
    output logic              op_valid,
    input  logic [15:0]       result,
    input  logic              result_valid,
    output logic              reg_we,
    output logic [2:0]        reg_widx,
    output logic [15:0]       reg_wdata,
    output logic              busy,
    output logic              done
`ifdef SEG_OVERRIDE_EN
    ,
    input  logic              seg_ovr_valid,
    input  logic [15:0]       seg_ovr
`endif
);

    state_e      state_q, state_d;
    logic [7:0]  modrm_q, modrm_d;
    logic        isize_q, isize_d, dir_q, dir_d, wb_q, wb_d;
    logic        rm_fetch_q, rm_fetch_d;
    logic [15:0] disp_q, disp_d, ea_q, ea_d, seg_q, seg_d;
    logic [15:0] opnd_q, opnd_d, rm_raw_q, rm_raw_d;
    logic [15:0] result_q, result_d, wdata_q, wdata_d;

    logic [15:0] ea_off, seg_dflt, seg_sel, reg_opnd, dst_raw, mem_off;
    logic [19:0] phys;
    logic        ea_use_ss, dst_is_reg, needs_disp;
    logic [2:0]  widx;

    ja88_ea u_ea (
        .modrm  (modrm_d),
        .disp   (disp_d),
        .bx     (bx),
        .bp     (bp),
        .si     (si),
        .di     (di),
        .offset (ea_off),
        .use_ss (ea_use_ss)
    );

    assign seg_dflt   = ea_use_ss ? seg_ss : seg_ds;
    assign dst_is_reg = dir_q || (modrm_q[7:6] == MOD_REG);
    assign widx       = dir_q ? modrm_q[5:3] : modrm_q[2:0];
    assign dst_raw    = dir_q ? reg_rdata : rm_raw_q;
    assign needs_disp = (modrm[7:6] == MOD_DISP8) || (modrm[7:6] == MOD_DISP16) ||
                        ((modrm[7:6] == MOD_MEM) && (modrm[2:0] == RM_BP));

`ifdef SEG_OVERRIDE_EN
    logic        ovr_v_q, ovr_v_d;
    logic [15:0] ovr_q, ovr_d;

    assign ovr_v_d = (state_q == ST_IDLE && start) ? seg_ovr_valid : ovr_v_q;
    assign ovr_d   = (state_q == ST_IDLE && start) ? seg_ovr : ovr_q;
    assign seg_sel = ovr_v_d ? ovr_d : seg_dflt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovr_v_q <= 1'b0;
            ovr_q   <= 16'h0000;
        end else begin
            ovr_v_q <= ovr_v_d;
            ovr_q   <= ovr_d;
        end
    end
`else
    assign seg_sel = seg_dflt;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            modrm_q    <= 8'h00;
            isize_q    <= 1'b0;
            dir_q      <= 1'b0;
            wb_q       <= 1'b0;
            rm_fetch_q <= 1'b0;
            disp_q     <= 16'h0000;
            ea_q       <= 16'h0000;
            seg_q      <= 16'h0000;
            opnd_q     <= 16'h0000;
            rm_raw_q   <= 16'h0000;
            result_q   <= 16'h0000;
            wdata_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            modrm_q    <= modrm_d;
            isize_q    <= isize_d;
            dir_q      <= dir_d;
            wb_q       <= wb_d;
            rm_fetch_q <= rm_fetch_d;
            disp_q     <= disp_d;
            ea_q       <= ea_d;
            seg_q      <= seg_d;
            opnd_q     <= opnd_d;
            rm_raw_q   <= rm_raw_d;
            result_q   <= result_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        modrm_d    = modrm_q;
        isize_d    = isize_q;
        dir_d      = dir_q;
        wb_d       = wb_q;
        rm_fetch_d = rm_fetch_q;
        disp_d     = disp_q;
        opnd_d     = opnd_q;
        rm_raw_d   = rm_raw_q;
        result_d   = result_q;
        wdata_d    = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    modrm_d = modrm;
                    isize_d = isize;
                    dir_d   = dir;
                    wb_d    = wb;
                    disp_d  = 16'h0000;
                    if (modrm[7:6] == MOD_REG) begin
                        state_d    = ST_EXEC;
                        rm_fetch_d = 1'b1;
                    end else if (needs_disp) begin
                        state_d = ST_DISP_LO;
                    end else begin
                        state_d = ST_READ_LO;
                    end
                end
            end
            ST_DISP_LO: begin
                if (ib_valid) begin
                    if (modrm_q[7:6] == MOD_DISP8) begin
                        disp_d  = {{8{ib_data[7]}}, ib_data};
                        state_d = ST_READ_LO;
                    end else begin
                        disp_d  = {8'h00, ib_data};
                        state_d = ST_DISP_HI;
                    end
                end
            end
            ST_DISP_HI: begin
                if (ib_valid) begin
                    disp_d  = {ib_data, disp_q[7:0]};
                    state_d = ST_READ_LO;
                end
            end
            ST_READ_LO: begin
                if (mem_ack) begin
                    opnd_d  = {8'h00, mem_rdata};
                    state_d = isize_q ? ST_READ_HI : ST_EXEC;
                end
            end
            ST_READ_HI: begin
                if (mem_ack) begin
                    opnd_d  = {mem_rdata, opnd_q[7:0]};
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Register-direct r/m is fetched through the shared read port first.
                if (rm_fetch_q) begin
                    rm_fetch_d = 1'b0;
                    rm_raw_d   = reg_rdata;
                    opnd_d     = reg_rd_sel(reg_rdata, modrm_q[2], isize_q);
                end else if (result_valid) begin
                    result_d = result;
                    wdata_d  = reg_wr_merge(dst_raw, result, widx[2], isize_q);
                    if (!wb_q || dst_is_reg)
                        state_d = ST_DONE;
                    else
                        state_d = ST_WRITE_LO;
                end
            end
            ST_WRITE_LO: begin
                if (mem_ack)
                    state_d = isize_q ? ST_WRITE_HI : ST_DONE;
            end
            ST_WRITE_HI: begin
                if (mem_ack)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Address is latched on entry to READ_LO so the bus stays stable through waits.
    always_comb begin
        ea_d  = ea_q;
        seg_d = seg_q;
        if (state_d == ST_READ_LO && state_q != ST_READ_LO) begin
            ea_d  = ea_off;
            seg_d = seg_sel;
        end
    end

    assign mem_off  = (state_q == ST_READ_HI || state_q == ST_WRITE_HI) ? ea_q + 16'd1 : ea_q;
    assign phys     = {seg_q, 4'h0} + {4'h0, mem_off};
    assign reg_opnd = reg_rd_sel(reg_rdata, modrm_q[5], isize_q);

    always_comb begin
        ib_ready  = (state_q == ST_DISP_LO) || (state_q == ST_DISP_HI);
        mem_rd    = (state_q == ST_READ_LO) || (state_q == ST_READ_HI);
        mem_wr    = (state_q == ST_WRITE_LO) || (state_q == ST_WRITE_HI);
        mem_addr  = (mem_rd || mem_wr) ? ADDR_W'(phys) : '0;
        mem_wdata = 8'h00;
        if (state_q == ST_WRITE_LO)
            mem_wdata = result_q[7:0];
        else if (state_q == ST_WRITE_HI)
            mem_wdata = result_q[15:8];
        reg_ridx  = (state_q == ST_EXEC && rm_fetch_q) ? modrm_q[2:0] : modrm_q[5:3];
        op_valid  = (state_q == ST_EXEC) && !rm_fetch_q;
        op1       = 16'h0000;
        op2       = 16'h0000;
        if (op_valid) begin
            op1 = dir_q ? reg_opnd : opnd_q;
            op2 = dir_q ? opnd_q : reg_opnd;
        end
        reg_we    = (state_q == ST_DONE) && wb_q && dst_is_reg;
        reg_widx  = reg_we ? widx : 3'd0;
        reg_wdata = reg_we ? wdata_q : 16'h0000;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_modrm_operand.sv
// Directed bench for modrm_operand: register, disp8, direct, wrap-around,
// SS-default/override, wait-state and mid-write reset cases.
module tb_modrm_operand;

    localparam int ADDR_W = 20;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        modrm = 8'h00;
    logic              isize = 1'b0, dir = 1'b0, wb = 1'b0;
    logic [15:0]       bx = 16'h0, bp = 16'h0, si = 16'h0, di = 16'h0;
    logic [15:0]       seg_ds = 16'h0, seg_ss = 16'h0;
    logic              ib_valid = 1'b0;
    logic [7:0]        ib_data = 8'h00;
    logic              ib_ready;
    logic [2:0]        reg_ridx;
    logic [15:0]       reg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd, mem_wr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;
    logic              mem_ack = 1'b0;
    logic [15:0]       op1, op2;
    logic              op_valid;
    logic [15:0]       result = 16'h0;
    logic              result_valid = 1'b0;
    logic              reg_we;
    logic [2:0]        reg_widx;
    logic [15:0]       reg_wdata;
    logic              busy, done;
`ifdef SEG_OVERRIDE_EN
    logic              seg_ovr_valid = 1'b0;
    logic [15:0]       seg_ovr = 16'h0;
`endif

    modrm_operand #(.ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .modrm(modrm),
        .isize(isize), .dir(dir), .wb(wb),
        .bx(bx), .bp(bp), .si(si), .di(di), .seg_ds(seg_ds), .seg_ss(seg_ss),
        .ib_valid(ib_valid), .ib_data(ib_data), .ib_ready(ib_ready),
        .reg_ridx(reg_ridx), .reg_rdata(reg_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .op1(op1), .op2(op2), .op_valid(op_valid),
        .result(result), .result_valid(result_valid),
        .reg_we(reg_we), .reg_widx(reg_widx), .reg_wdata(reg_wdata),
        .busy(busy), .done(done)
`ifdef SEG_OVERRIDE_EN
        , .seg_ovr_valid(seg_ovr_valid), .seg_ovr(seg_ovr)
`endif
    );

    always #5 clock = ~clock;

    // Register file: byte operands (isize=0) map index to word idx[1:0].
    logic [15:0] regs [8];
    assign reg_rdata = regs[isize ? reg_ridx : {1'b0, reg_ridx[1:0]}];

    logic [7:0]  mem [logic [19:0]];
    logic [19:0] acc_addr [$];
    logic        acc_wr [$];
    logic [7:0]  acc_data [$];
    logic [7:0]  dq [$];
    int          ack_delay = 0;
    int          stable_err = 0;
    logic        stall_en = 1'b0;
    logic [19:0] stall_addr = 20'h0;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Byte memory slave with programmable wait states and an optional write stall.
    initial begin : mem_resp
        int          cnt;
        logic [19:0] a0;
        cnt = 0;
        a0  = 20'h0;
        forever begin
            @(posedge clock); #1;
            if (!reset_n) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_rd || mem_wr) begin
                if (cnt == 0) a0 = mem_addr;
                else if (mem_addr !== a0) stable_err++;
                if (cnt >= ack_delay && !(stall_en && mem_wr && mem_addr == stall_addr)) begin
                    mem_ack = 1'b1;
                    if (mem_rd) mem_rdata = mem[mem_addr];
                    else        mem[mem_addr] = mem_wdata;
                    acc_addr.push_back(mem_addr);
                    acc_wr.push_back(mem_wr);
                    acc_data.push_back(mem_rd ? mem[mem_addr] : mem_wdata);
                end
                cnt++;
            end
        end
    end

    initial begin : ib_resp
        logic       acc;
        logic [7:0] dummy;
        acc = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset_n) begin
                acc      = 1'b0;
                ib_valid = 1'b0;
            end else begin
                if (acc && dq.size() > 0) dummy = dq.pop_front();
                ib_valid = ib_ready && (dq.size() > 0);
                ib_data  = (dq.size() > 0) ? dq[0] : 8'h00;
                acc      = ib_valid;
            end
        end
    end

    task automatic clear_log();
        acc_addr.delete();
        acc_wr.delete();
        acc_data.delete();
        stable_err = 0;
    endtask

    task automatic start_op(input logic [7:0] m, input logic sz, input logic d, input logic w);
        @(posedge clock); #1;
        modrm = m; isize = sz; dir = d; wb = w; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic alu_step(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                            input logic [15:0] res);
        int n;
        n = 0;
        while (!op_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        repeat (2) begin @(posedge clock); #1; end
        chk({tag, "_op_valid"}, op_valid, 1'b1);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_op1"}, op1, e1);
        chk({tag, "_op2"}, op2, e2);
        result = res;
        result_valid = 1'b1;
        @(posedge clock); #1;
        result_valid = 1'b0;
        result = 16'h0;
    endtask

    task automatic finish_op(input string tag, input logic exp_we, input logic [2:0] exp_idx,
                             input logic [15:0] exp_wd);
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_reg_we"}, reg_we, exp_we);
        if (exp_we) begin
            chk({tag, "_reg_widx"}, reg_widx, exp_idx);
            chk({tag, "_reg_wdata"}, reg_wdata, exp_wd);
        end
        @(posedge clock); #1;
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic reg_case(input string tag);
        regs[0] = 16'h0005;
        regs[3] = 16'h0007;
        clear_log();
        start_op(8'hC3, 1'b1, 1'b0, 1'b1);
        alu_step(tag, 16'h0007, 16'h0005, 16'h000C);
        finish_op(tag, 1'b1, 3'd3, 16'h000C);
        chk({tag, "_no_mem"}, acc_addr.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int   n;
        logic seen;
        logic [19:0] exp_a;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ib_ready", ib_ready, 1'b0);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_reg_we", reg_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 20'h0);
        chk("rst_op1", op1, 16'h0);
        chk("rst_op2", op2, 16'h0);
        reset_n = 1'b1;

        // mod=3 register-to-register
        reg_case("reg");

        // mod=1 BX+disp8 (FE), read-modify-write to memory
        bx = 16'h1000; seg_ds = 16'h2000; regs[0] = 16'h0001;
        mem[20'h20FFE] = 8'h34; mem[20'h20FFF] = 8'h12;
        clear_log();
        dq.push_back(8'hFE);
        start_op(8'h47, 1'b1, 1'b0, 1'b1);
        alu_step("d8", 16'h1234, 16'h0001, 16'h1235);
        finish_op("d8", 1'b0, 3'd0, 16'h0);
        chk("d8_nacc", acc_addr.size(), 4);
        if (acc_addr.size() == 4) begin
            chk("d8_a0", {acc_wr[0], acc_addr[0]}, {1'b0, 20'h20FFE});
            chk("d8_a1", {acc_wr[1], acc_addr[1]}, {1'b0, 20'h20FFF});
            chk("d8_a2", {acc_wr[2], acc_addr[2], acc_data[2]}, {1'b1, 20'h20FFE, 8'h35});
            chk("d8_a3", {acc_wr[3], acc_addr[3], acc_data[3]}, {1'b1, 20'h20FFF, 8'h12});
        end

        // direct address, wb=0, 3 wait states, start while busy ignored
        ack_delay = 3; seg_ds = 16'h2000; regs[0] = 16'h0001;
        mem[20'h21234] = 8'h5A;
        clear_log();
        dq.push_back(8'h34); dq.push_back(8'h12);
        start_op(8'h06, 1'b0, 1'b0, 1'b0);
        modrm = 8'hC0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; modrm = 8'h06;
        alu_step("dir", 16'h005A, 16'h0001, 16'h0059);
        finish_op("dir", 1'b0, 3'd0, 16'h0);
        chk("dir_nacc", acc_addr.size(), 1);
        if (acc_addr.size() == 1)
            chk("dir_addr", {acc_wr[0], acc_addr[0]}, {1'b0, 20'h21234});
        chk("dir_stable", stable_err, 0);
        ack_delay = 0;

        // EA=FFFF wraps for the high byte, register destination
        si = 16'hFFFF; seg_ds = 16'h0000; regs[0] = 16'h0001;
        mem[20'h0FFFF] = 8'hCD; mem[20'h00000] = 8'hAB;
        clear_log();
        start_op(8'h04, 1'b1, 1'b1, 1'b1);
        alu_step("wrap", 16'h0001, 16'hABCD, 16'h1111);
        finish_op("wrap", 1'b1, 3'd0, 16'h1111);
        chk("wrap_nacc", acc_addr.size(), 2);
        if (acc_addr.size() == 2) begin
            chk("wrap_lo", acc_addr[0], 20'h0FFFF);
            chk("wrap_hi", acc_addr[1], 20'h00000);
        end

        // BP+disp8 defaults to SS; byte reg AH destination with merge
        bp = 16'h0010; seg_ss = 16'h3000; seg_ds = 16'h2000; regs[0] = 16'h1234;
        mem[20'h30010] = 8'h05; mem[20'h40010] = 8'h05;
        exp_a = 20'h30010;
`ifdef SEG_OVERRIDE_EN
        seg_ovr_valid = 1'b1; seg_ovr = 16'h4000;
        exp_a = 20'h40010;
`endif
        clear_log();
        dq.push_back(8'h00);
        start_op(8'h66, 1'b0, 1'b1, 1'b1);
`ifdef SEG_OVERRIDE_EN
        seg_ovr_valid = 1'b0; seg_ovr = 16'h0;
`endif
        alu_step("ss", 16'h0012, 16'h0005, 16'h0017);
        finish_op("ss", 1'b1, 3'd4, 16'h1734);
        chk("ss_nacc", acc_addr.size(), 1);
        if (acc_addr.size() == 1)
            chk("ss_addr", acc_addr[0], exp_a);

        // reset while WRITE_HI is waiting for ack
        bx = 16'h0100; seg_ds = 16'h0000; regs[0] = 16'h0003;
        mem[20'h00100] = 8'h11; mem[20'h00101] = 8'h22;
        stall_en = 1'b1; stall_addr = 20'h00101;
        clear_log();
        start_op(8'h07, 1'b1, 1'b0, 1'b1);
        alu_step("rstw", 16'h2211, 16'h0003, 16'h2214);
        n = 0;
        while (!(mem_wr && mem_addr == 20'h00101) && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk("rstw_in_write_hi", {mem_wr, mem_addr}, {1'b1, 20'h00101});
        #1 reset_n = 1'b0;
        #1;
        chk("rstw_mem_wr", mem_wr, 1'b0);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_mem_addr", mem_addr, 20'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        stall_en = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            if (mem_wr || busy) seen = 1'b1;
        end
        chk("rstw_quiet", seen, 1'b0);
        chk("rstw_hi_kept", mem[20'h00101], 8'h22);
        chk("rstw_lo_written", mem[20'h00100], 8'h14);
        chk("rstw_nacc", acc_addr.size(), 3);

        // normal operation after reset
        reg_case("post");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
